// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding word reads and buffers
// returned instructions toward decode; branch redirects flush. Optional FETCH_PERF_CNT_EN counters.
module fetch_redirect_unit #(
    parameter int unsigned       ADDR_W     = 10,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              branch,
    input  logic [ADDR_W-1:0] targetAddress,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_redirects,
    output logic [31:0]       perf_dropped
`endif
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              drop_q, drop_d;

    logic [DATA_W-1:0] data_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] addr_q [FIFO_DEPTH];
    logic [PtrW-1:0]   rptr_q, wptr_q;
    logic [CntW-1:0]   cnt_q;

    logic hs, push, pop;

    // A request only issues with no response outstanding, so free entries here already
    // account for the reserved slot of the in-flight response.
    assign imem_req    = (state_q == StReq) && (cnt_q < CntW'(FIFO_DEPTH));
    assign imem_addr   = pc_q;
    assign hs          = imem_req & imem_gnt;
    assign instr_valid = (cnt_q != '0);
    assign instr       = data_q[rptr_q];
    assign instr_addr  = addr_q[rptr_q];
    assign pop         = instr_valid & instr_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        drop_d     = drop_q;
        push       = 1'b0;
        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (hs) begin
                    pc_d       = pc_q + ADDR_W'(1);
                    req_addr_d = pc_q;
                    drop_d     = branch;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    push    = ~(drop_q | branch);
                    drop_d  = 1'b0;
                    state_d = StReq;
                end else if (branch) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (branch) begin
            pc_d = targetAddress;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            drop_q     <= drop_d;
        end
    end

    // Push never coincides with a redirect, so the flush can simply snap rptr to wptr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            if (push) begin
                data_q[wptr_q] <= imem_rdata;
                addr_q[wptr_q] <= req_addr_q;
                wptr_q         <= wptr_q + PtrW'(1);
            end
            if (branch) begin
                rptr_q <= wptr_q;
                cnt_q  <= '0;
            end else begin
                if (pop) begin
                    rptr_q <= rptr_q + PtrW'(1);
                end
                cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_redir_q, perf_drop_q, drop_inc;
    logic [32:0] redir_sum, drop_sum;

    always_comb begin
        drop_inc = '0;
        if ((state_q == StWait) && imem_rvalid && (drop_q || branch)) begin
            drop_inc = 32'd1;
        end
        if (branch) begin
            drop_inc = drop_inc + 32'(cnt_q) - 32'(pop);
        end
        redir_sum = {1'b0, perf_redir_q} + 33'(branch);
        drop_sum  = {1'b0, perf_drop_q} + {1'b0, drop_inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_redir_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            perf_redir_q <= redir_sum[32] ? '1 : redir_sum[31:0];
            perf_drop_q  <= drop_sum[32] ? '1 : drop_sum[31:0];
        end
    end

    assign perf_redirects = perf_redir_q;
    assign perf_dropped   = perf_drop_q;
`endif

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Instruction-fetch front end; consumes the `branch` / `targetAddress` pair produced by the branch unit.
- Owns the PC, issues word reads to instruction memory and buffers returned instructions in a small FIFO toward decode.
- On a taken branch or jump it flushes buffered and in-flight fetches and restarts at the target address.

Parameters:
- ADDR_W, 10, PC / instruction-memory word-address width (matches the branch unit's targetAddress).
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC value after reset.
- FIFO_DEPTH, 2, decode-side instruction buffer entries (power of two, ≥2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- branch  in  1  redirect request from the branch unit, single-cycle qualifier.
- targetAddress  in  ADDR_W  redirect target, valid when branch=1.
- imem_req  out  1  read request; held until accepted.
- imem_addr  out  ADDR_W  word address of the request.
- imem_gnt  in  1  memory accepts the request this cycle (req&gnt = handshake).
- imem_rvalid  in  1  read data valid; exactly one per accepted request, ≥1 cycle after accept, in order.
- imem_rdata  in  DATA_W  read data.
- instr_valid  out  1  FIFO head valid toward decode.
- instr  out  DATA_W  FIFO head instruction.
- instr_addr  out  ADDR_W  address of FIFO head instruction.
- instr_ready  in  1  decode consumes head when instr_valid&instr_ready.

Behaviour:
- Reset values (async, rst_n=0):
  - pc=RESET_PC; state=IDLE.
  - imem_req=0; imem_addr=RESET_PC.
  - FIFO empty; instr_valid=0; instr=0; instr_addr=0.
  - drop=0.
- At most one outstanding memory request.
- State machine:
  - IDLE: first cycle after reset release → REQ.
  - REQ: imem_req=1, imem_addr=pc.
    - Enter REQ only if FIFO free entries > 0; otherwise wait in REQ with imem_req=0.
    - On req&gnt: pc ← pc+1 (mod 2^ADDR_W, 1023→0 wraps), → WAIT.
    - imem_addr must not change while req=1 and gnt=0, unless a redirect occurs.
  - WAIT: on imem_rvalid:
    - If drop=0: push {imem_rdata, addr_of_request} into the FIFO.
    - If drop=1: discard the data and clear drop.
    - Then → REQ.
- Redirect (branch=1, any state), effective at that clock edge:
  - pc ← targetAddress; FIFO flushed (instr_valid=0 next cycle).
  - A decode pop coinciding with the redirect is honoured; the flush still empties the FIFO.
  - In WAIT with no rvalid in the same cycle: drop ← 1; stay WAIT.
  - In WAIT with rvalid in the same cycle: response discarded, not pushed; → REQ.
  - In REQ with gnt in the same cycle: the granted request is in flight; drop ← 1; → WAIT; pc = targetAddress (no increment).
  - In REQ without gnt: next cycle imem_addr=targetAddress.
- Latency: redirect at edge N → imem_req with imem_addr=targetAddress no earlier than cycle N+1. Earliest instr_valid for the target is one cycle after its rvalid.
- FIFO:
  - Push and pop in the same cycle are allowed when not full.
  - A full FIFO blocks new requests. The in-flight response always has a reserved entry, because a request issues only when free ≥1 counting the outstanding request.
  - Head outputs are registered.
- Back-to-back redirects: the latest one wins; drop stays 1 (a single in-flight response is discarded).
- Reset mid-operation: all state cleared. Any response arriving after reset release with no request outstanding is ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_redirects (32) and perf_dropped (32), both reset to 0.
  - perf_redirects increments on every branch=1 cycle.
  - perf_dropped increments per discarded rvalid plus per flushed FIFO entry.
  - Both saturate at all-ones.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset release, memory gnt immediate, rvalid 1 cycle later, instr_ready=1 → imem_addr sequence 0,1,2,3; instr_addr 0,1,2,3 in order with matching data.
- instr_ready=0 for 10 cycles → exactly 2 instructions buffered, imem_req stays 0 after FIFO fills; on ready=1, addresses resume contiguously with no gap or duplicate.
- branch=1, targetAddress=0x1F0 while in WAIT, rvalid 3 cycles later → that response discarded; next imem_addr=0x1F0; next instr_addr=0x1F0.
- branch=1 with targetAddress=0x3FF, then sequential fetch → imem_addr 0x3FF then 0x000 (wrap).
- branch coincident with req&gnt and with rvalid (separate runs) → no instruction from the old path reaches decode; first delivered instr_addr = target.
- rst_n asserted mid-WAIT with FIFO holding 1 entry → instr_valid=0, imem_req=0 immediately; after release, fetch restarts at RESET_PC.
